// File: rtl/a2bus_arb_pkg.sv
// a2bus_arb_pkg: shared types and helpers for the Apple II bus-driver arbiter.
package a2bus_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  // Isolates the lowest set bit: x & -x, written with an explicit width.
  function automatic logic [MAX_REQ-1:0] prio_onehot(logic [MAX_REQ-1:0] req);
    return req & (~req + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/prio_encoder.sv
// prio_encoder: fixed-priority (index 0 wins) one-hot and index encoder with multi-hit flag.
module prio_encoder
  import a2bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o,
  output logic               multi_o
);

  assign onehot_o = NUM_REQ'(prio_onehot(MAX_REQ'(req_i)));
  assign any_o    = |req_i;
  assign multi_o  = ($countones(req_i) > 1);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_drive_arbiter.sv
// bus_drive_arbiter: grants the Apple II data-bus driver to one slot card per bus cycle.
// Build option: define BUS_ARB_CONFLICT_COUNT_EN to include the saturating collision counter.
module bus_drive_arbiter
  import a2bus_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                   clk_logic,
  input  logic                   reset,
  input  logic                   phi0,
  input  logic                   phi1_posedge,
  input  logic                   rw_n,
  input  logic [NUM_REQ-1:0]     req_rd_en_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_irq_n_i,
  input  logic [NUM_REQ-1:0]     irq_mask_i,
  output logic                   data_out_en_o,
  output logic [7:0]             data_out_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   irq_n_o,
  output logic                   conflict_o,
  output logic [7:0]             conflict_count_o
);

  localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);

  arb_state_t          state_q;
  logic                served_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                en_q;
  logic [7:0]          data_q;
  logic [3:0]          holdCnt_q;
  logic                conflict_q;
  logic                irqN_q;
  logic                irqN_d;

  logic [NUM_REQ-1:0]  encOneHot;
  logic [IDX_W-1:0]    encIdx;
  logic                encAny;
  logic                encMulti;
  logic [7:0]          newData;
  logic [7:0]          grantedData;
  logic                grantedReq;
  logic                grantNow;

  prio_encoder #(
    .NUM_REQ (NUM_REQ)
  ) u_prio (
    .req_i    (req_rd_en_i),
    .onehot_o (encOneHot),
    .idx_o    (encIdx),
    .any_o    (encAny),
    .multi_o  (encMulti)
  );

  // newData feeds a fresh grant; grantedData follows the current owner while driving.
  always_comb begin
    newData     = 8'h00;
    grantedData = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (encIdx == IDX_W'(i)) begin
        newData = req_data_i[i*8 +: 8];
      end
      if (grant_q[i]) begin
        grantedData = grantedData | req_data_i[i*8 +: 8];
      end
    end
  end

  assign grantedReq = |(req_rd_en_i & grant_q);
  assign grantNow   = (state_q == IDLE) && phi0 && rw_n && encAny && !served_q && !phi1_posedge;

  always_comb begin
    irqN_d = &(req_irq_n_i | ~irq_mask_i);
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state_q    <= IDLE;
      served_q   <= 1'b0;
      grant_q    <= '0;
      en_q       <= 1'b0;
      data_q     <= 8'h00;
      holdCnt_q  <= 4'd0;
      conflict_q <= 1'b0;
    end else begin
      if (phi1_posedge) begin
        served_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (grantNow) begin
            state_q  <= DRIVE;
            served_q <= 1'b1;
            grant_q  <= encOneHot;
            en_q     <= 1'b1;
            data_q   <= newData;
            if (encMulti) begin
              conflict_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          data_q <= grantedData;
          if (phi1_posedge || !grantedReq) begin
            if (HOLD_CYCLES == 0) begin
              state_q <= IDLE;
              grant_q <= '0;
              en_q    <= 1'b0;
              data_q  <= 8'h00;
            end else begin
              state_q   <= HOLD;
              holdCnt_q <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (holdCnt_q == 4'd0) begin
            state_q <= IDLE;
            grant_q <= '0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
          end else begin
            holdCnt_q <= holdCnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          en_q    <= 1'b0;
          data_q  <= 8'h00;
        end
      endcase
    end
  end

  // IRQ aggregation runs independently of the bus FSM.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      irqN_q <= 1'b1;
    end else begin
      irqN_q <= irqN_d;
    end
  end

`ifdef BUS_ARB_CONFLICT_COUNT_EN
  logic [7:0] conflictCnt_q;
  logic [7:0] conflictCnt_d;

  // Saturate at 255 so a long-running collision never reads back as zero.
  always_comb begin
    conflictCnt_d = conflictCnt_q;
    if (grantNow && encMulti && (conflictCnt_q != 8'hFF)) begin
      conflictCnt_d = conflictCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      conflictCnt_q <= 8'h00;
    end else begin
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign conflict_count_o = conflictCnt_q;
`else
  assign conflict_count_o = 8'h00;
`endif

  assign data_out_en_o = en_q;
  assign data_out_o    = data_q;
  assign grant_o       = grant_q;
  assign irq_n_o       = irqN_q;
  assign conflict_o    = conflict_q;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// tb_bus_drive_arbiter: directed and randomized bus cycles checked against a transaction-level model.
module tb_bus_drive_arbiter;

  localparam int NUM  = 4;
  localparam int HOLD = 3;

  logic              clk_logic = 1'b0;
  logic              reset;
  logic              phi0;
  logic              phi1_posedge;
  logic              rw_n;
  logic [NUM-1:0]    req_rd_en_i;
  logic [NUM*8-1:0]  req_data_i;
  logic [NUM-1:0]    req_irq_n_i;
  logic [NUM-1:0]    irq_mask_i;
  logic              data_out_en_o;
  logic [7:0]        data_out_o;
  logic [NUM-1:0]    grant_o;
  logic              irq_n_o;
  logic              conflict_o;
  logic [7:0]        conflict_count_o;

  int   total = 0;
  int   bad   = 0;
  logic expConflict = 1'b0;
  int   expCount    = 0;

  bus_drive_arbiter #(
    .NUM_REQ     (NUM),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_logic        (clk_logic),
    .reset            (reset),
    .phi0             (phi0),
    .phi1_posedge     (phi1_posedge),
    .rw_n             (rw_n),
    .req_rd_en_i      (req_rd_en_i),
    .req_data_i       (req_data_i),
    .req_irq_n_i      (req_irq_n_i),
    .irq_mask_i       (irq_mask_i),
    .data_out_en_o    (data_out_en_o),
    .data_out_o       (data_out_o),
    .grant_o          (grant_o),
    .irq_n_o          (irq_n_o),
    .conflict_o       (conflict_o),
    .conflict_count_o (conflict_count_o)
  );

  always #5 clk_logic = ~clk_logic;

  task automatic step();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic p0, input logic p1, input logic rw,
                               input logic [NUM-1:0] req, input logic [NUM*8-1:0] data);
    phi0         = p0;
    phi1_posedge = p1;
    rw_n         = rw;
    req_rd_en_i  = req;
    req_data_i   = data;
  endtask

  task automatic checkConflict(input string tag);
    checkOutput({tag, "_conflict"}, conflict_o, expConflict);
`ifdef BUS_ARB_CONFLICT_COUNT_EN
    checkOutput({tag, "_count"}, conflict_count_o, expCount);
`else
    checkOutput({tag, "_count"}, conflict_count_o, 0);
`endif
  endtask

  function automatic int irqModel(input logic [NUM-1:0] irqN, input logic [NUM-1:0] mask);
    int v;
    v = 1;
    for (int i = 0; i < NUM; i++) begin
      if (mask[i] && !irqN[i]) v = 0;
    end
    return v;
  endfunction

  // End the bus cycle and let any hold period run out.
  task automatic drainBus(input string tag);
    phi0         = 1'b0;
    phi1_posedge = 1'b1;
    step();
    phi1_posedge = 1'b0;
    req_rd_en_i  = '0;
    repeat (HOLD + 1) step();
    checkOutput({tag, "_drain_en"}, data_out_en_o, 0);
    checkOutput({tag, "_drain_grant"}, grant_o, 0);
  endtask

  // One full bus cycle: phi0 window with the given requests, then phi1 edge and hold.
  task automatic readCycle(input logic [NUM-1:0] req, input logic rwVal,
                           input logic [NUM*8-1:0] dataIn, input string tag);
    int             win;
    logic           willGrant;
    logic           multi;
    logic [NUM-1:0] expGrant;
    logic [7:0]     lastData;
    logic [NUM*8-1:0] dataVec;
    win = -1;
    for (int i = 0; i < NUM; i++) begin
      if (req[i] && win < 0) win = i;
    end
    willGrant = rwVal && (win >= 0);
    multi     = ($countones(req) > 1);
    expGrant  = '0;
    lastData  = 8'h00;
    if (willGrant) begin
      expGrant[win] = 1'b1;
      lastData      = dataIn[win*8 +: 8];
    end
    dataVec = dataIn;
    applyStimulus(1'b1, 1'b0, rwVal, req, dataVec);
    step();
    if (willGrant && multi) begin
      expConflict = 1'b1;
      if (expCount < 255) expCount++;
    end
    checkOutput({tag, "_en"}, data_out_en_o, willGrant);
    checkOutput({tag, "_grant"}, grant_o, expGrant);
    checkOutput({tag, "_data"}, data_out_o, lastData);
    checkConflict(tag);
    dataVec    = {$urandom};
    req_data_i = dataVec;
    step();
    if (willGrant) lastData = dataVec[win*8 +: 8];
    checkOutput({tag, "_track"}, data_out_o, lastData);
    step();
    phi0         = 1'b0;
    phi1_posedge = 1'b1;
    step();
    phi1_posedge = 1'b0;
    req_rd_en_i  = '0;
    req_data_i   = {$urandom};
    for (int k = 1; k <= HOLD + 1; k++) begin
      checkOutput({tag, "_hold_en"}, data_out_en_o, willGrant && (k <= HOLD));
      if (k <= HOLD) begin
        checkOutput({tag, "_hold_data"}, data_out_o, lastData);
      end else begin
        checkOutput({tag, "_rel_data"}, data_out_o, 0);
        checkOutput({tag, "_rel_grant"}, grant_o, 0);
      end
      step();
    end
  endtask

  initial begin
    logic [NUM-1:0] rq;
    logic [NUM-1:0] irqv;
    logic [NUM-1:0] mk;
    logic [7:0]     frozen;

    reset       = 1'b1;
    req_irq_n_i = '1;
    irq_mask_i  = '0;
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    step();
    step();
    checkOutput("rst_en", data_out_en_o, 0);
    checkOutput("rst_data", data_out_o, 0);
    checkOutput("rst_grant", grant_o, 0);
    checkOutput("rst_irq", irq_n_o, 1);
    checkConflict("rst");
    reset = 1'b0;
    step();

    $display("[TB] single read");
    readCycle(4'b0100, 1'b1, 32'h00A5_0000, "single");

    $display("[TB] collisions");
    readCycle(4'b0011, 1'b1, 32'h0000_2211, "coll1");
    readCycle(4'b0011, 1'b1, 32'h0000_2211, "coll2");

    $display("[TB] write cycle");
    readCycle(4'b0001, 1'b0, 32'h1234_5678, "write");
    readCycle(4'b1011, 1'b0, 32'h1234_5678, "writecoll");

    $display("[TB] early drop");
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0100, 32'h0077_0000);
    step();
    checkOutput("drop_en", data_out_en_o, 1);
    checkOutput("drop_grant", grant_o, 4'b0100);
    frozen      = 8'h77;
    req_rd_en_i = '0;
    step();
    req_rd_en_i = 4'b0100;
    req_data_i  = 32'h00EE_0000;
    for (int k = 1; k <= HOLD + 1; k++) begin
      checkOutput("drop_hold_en", data_out_en_o, k <= HOLD);
      if (k <= HOLD) checkOutput("drop_hold_data", data_out_o, frozen);
      step();
    end
    step();
    checkOutput("drop_noregrant", data_out_en_o, 0);
    phi0         = 1'b0;
    phi1_posedge = 1'b1;
    step();
    phi1_posedge = 1'b0;
    phi0         = 1'b1;
    step();
    checkOutput("drop_regrant_en", data_out_en_o, 1);
    checkOutput("drop_regrant_data", data_out_o, 8'hEE);
    drainBus("drop");

    $display("[TB] phi1 strobe with request");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0001, 32'h0000_0042);
    step();
    checkOutput("strobe_nogrant", data_out_en_o, 0);
    phi1_posedge = 1'b0;
    step();
    checkOutput("strobe_later_en", data_out_en_o, 1);
    checkOutput("strobe_later_grant", grant_o, 4'b0001);
    drainBus("strobe");

    $display("[TB] irq mask");
    req_irq_n_i = 4'b1101;
    irq_mask_i  = 4'b0000;
    step();
    checkOutput("irq_masked", irq_n_o, 1);
    irq_mask_i = 4'b0010;
    #1;
    checkOutput("irq_latency", irq_n_o, 1);
    step();
    checkOutput("irq_fwd", irq_n_o, 0);
    for (int n = 0; n < 20; n++) begin
      irqv        = NUM'($urandom);
      mk          = NUM'($urandom);
      req_irq_n_i = irqv;
      irq_mask_i  = mk;
      step();
      checkOutput("irq_rand", irq_n_o, irqModel(irqv, mk));
    end

    $display("[TB] reset mid-drive");
    req_irq_n_i = '0;
    irq_mask_i  = '1;
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_3399);
    step();
    expConflict = 1'b1;
    if (expCount < 255) expCount++;
    checkOutput("mid_en", data_out_en_o, 1);
    checkOutput("mid_irq", irq_n_o, 0);
    checkConflict("mid");
    reset = 1'b1;
    step();
    reset       = 1'b0;
    expConflict = 1'b0;
    expCount    = 0;
    checkOutput("mrst_en", data_out_en_o, 0);
    checkOutput("mrst_data", data_out_o, 0);
    checkOutput("mrst_grant", grant_o, 0);
    checkOutput("mrst_irq", irq_n_o, 1);
    checkConflict("mrst");
    step();
    expConflict = 1'b1;
    expCount    = 1;
    checkOutput("post_en", data_out_en_o, 1);
    checkOutput("post_grant", grant_o, 4'b0001);
    checkOutput("post_data", data_out_o, 8'h99);
    checkConflict("post");
    req_irq_n_i = '1;
    drainBus("post");

    $display("[TB] random cycles");
    for (int n = 0; n < 40; n++) begin
      rq = NUM'($urandom);
      readCycle(rq, ($urandom_range(0, 3) != 0), {$urandom}, "rand");
    end

    $display("[TB] saturation");
    for (int n = 0; n < 260; n++) begin
      readCycle(4'b0110, 1'b1, {$urandom}, "sat");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
